// File: rtl/wb_slave_mux.sv
// -----------------------------------------------------------------------------
// wb_slave_mux
//
// Wishbone address-decoding mux: one upstream master, NS downstream slaves,
// exactly one outstanding transaction. A request is latched in IDLE, decoded
// from wbs_adr_i[31:24] (must equal BASE) and wbs_adr_i[18:16] (slave index).
// It is then forwarded to the selected slave (BUSY), and answered to the
// master with a single-cycle registered acknowledge (DONE). Bad decodes are
// answered with an error response: data 32'hDEADBEEF, a bus_err_o pulse, and
// the offending address captured in err_adr_o.
//
// Optional feature: define WB_SLAVE_MUX_TIMEOUT_EN to add a 16-bit stall
// counter. It turns a slave that stalls TIMEOUT cycles into an error
// response. Without the macro, BUSY waits indefinitely for an ack or a
// master abort.
//
// Parameters
//   NS       number of downstream slaves (1..8)
//   BASE     required value of wbs_adr_i[31:24]
//   TIMEOUT  stall limit in BUSY cycles (1..65535), used only with the macro
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock; asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i   master cycle, strobe, write enable
//   wbs_sel_i/adr_i/dat_i  master byte selects, address, write data
//   wbs_ack_o, wbs_dat_o   registered acknowledge and read data to master
//   s_cyc_o, s_stb_o       one-hot per-slave cycle/strobe (combinational)
//   s_we_o/sel_o/adr_o/dat_o  latched request, shared by all slaves
//   s_dat_i, s_ack_i       slave read data (slave k at [32k+31:32k]), acks
//   bus_err_o, err_adr_o   error pulse and address of the last error
// -----------------------------------------------------------------------------
module wb_slave_mux #(
  parameter int         NS      = 4,
  parameter logic [7:0] BASE    = 8'h30,
  parameter int         TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic             bus_err_o,
  output logic [31:0]      err_adr_o
);

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Elaboration-time parameter range checks.
  if (NS < 1 || NS > 8) begin : g_bad_ns
    $error("wb_slave_mux: NS must be in 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_slave_mux: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg,   state_next;
  logic [2:0]  idx_reg,     idx_next;
  logic        we_reg,      we_next;
  logic [3:0]  sel_reg,     sel_next;
  logic [31:0] adr_reg,     adr_next;
  logic [31:0] wdat_reg,    wdat_next;
  logic        ack_reg,     ack_next;
  logic [31:0] rdat_reg,    rdat_next;
  logic        berr_reg,    berr_next;
  logic [31:0] err_adr_reg, err_adr_next;

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  logic [15:0] cnt_reg, cnt_next;
  logic        cnt_expire;
`endif

  logic          dec_valid;
  logic [NS-1:0] slv_hit;
  logic          sel_ack;
  logic [31:0]   sel_rdata;
  logic          in_busy;

  // Decode of the incoming address, only meaningful while a request is
  // presented in IDLE. The index is widened so NS=8 compares cleanly.
  assign dec_valid = (wbs_adr_i[31:24] == BASE) &&
                     ({1'b0, wbs_adr_i[18:16]} < 4'(NS));

  assign in_busy = (state_reg == BUSY);

  // Per-slave hit from the latched index; strobes are combinational so a
  // reset drops them in the same instant the state register clears.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slave
    assign slv_hit[gi] = (idx_reg == 3'(gi));
    assign s_cyc_o[gi] = in_busy && slv_hit[gi];
    assign s_stb_o[gi] = in_busy && slv_hit[gi];
  end

  // Read-data / ack select. Acks from unselected slaves never reach the FSM.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (slv_hit[i]) begin
        sel_rdata = s_dat_i[i*32 +: 32];
        sel_ack   = s_ack_i[i];
      end
    end
  end

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  // The counter holds the number of completed BUSY cycles; the timeout fires
  // on the edge where it would reach TIMEOUT, so an ack presented in that
  // same cycle still takes priority below.
  assign cnt_expire = ((cnt_reg + 16'd1) == TIMEOUT_W);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    we_next      = we_reg;
    sel_next     = sel_reg;
    adr_next     = adr_reg;
    wdat_next    = wdat_reg;
    ack_next     = 1'b0;
    rdat_next    = rdat_reg;
    berr_next    = 1'b0;
    err_adr_next = err_adr_reg;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    cnt_next     = cnt_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_next   = wbs_we_i;
          sel_next  = wbs_sel_i;
          adr_next  = wbs_adr_i;
          wdat_next = wbs_dat_i;
          idx_next  = wbs_adr_i[18:16];
          if (dec_valid) begin
            state_next = BUSY;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end else begin
            // Decode error: the slave is never strobed, writes are dropped.
            state_next   = DONE;
            ack_next     = 1'b1;
            rdat_next    = ERR_DATA;
            berr_next    = 1'b1;
            err_adr_next = wbs_adr_i;
          end
        end
      end

      BUSY: begin
        // Priority: master abort, then slave ack, then timeout.
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (sel_ack) begin
          state_next = DONE;
          ack_next   = 1'b1;
          rdat_next  = we_reg ? 32'h0 : sel_rdata;
        end
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
        else if (cnt_expire) begin
          state_next   = DONE;
          ack_next     = 1'b1;
          rdat_next    = ERR_DATA;
          berr_next    = 1'b1;
          err_adr_next = adr_reg;
          cnt_next     = TIMEOUT_W;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
`endif
      end

      DONE: begin
        // Single-cycle response; new requests are only accepted in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      we_reg      <= 1'b0;
      sel_reg     <= '0;
      adr_reg     <= '0;
      wdat_reg    <= '0;
      ack_reg     <= 1'b0;
      rdat_reg    <= '0;
      berr_reg    <= 1'b0;
      err_adr_reg <= '0;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
      cnt_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      we_reg      <= we_next;
      sel_reg     <= sel_next;
      adr_reg     <= adr_next;
      wdat_reg    <= wdat_next;
      ack_reg     <= ack_next;
      rdat_reg    <= rdat_next;
      berr_reg    <= berr_next;
      err_adr_reg <= err_adr_next;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
      cnt_reg     <= cnt_next;
`endif
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdat_reg;
  assign bus_err_o = berr_reg;
  assign err_adr_o = err_adr_reg;
  assign s_we_o    = we_reg;
  assign s_sel_o   = sel_reg;
  assign s_adr_o   = adr_reg;
  assign s_dat_o   = wdat_reg;

endmodule

// File: doc/wb_slave_mux.md
WB_SLAVE_MUX -- requirements
Module: wb_slave_mux

Interface
REQ-001 Parameter NS, default 4: number of downstream Wishbone slaves (1..8).
REQ-002 Parameter BASE, default 8'h30: required value of wbs_adr_i[31:24].
REQ-003 Parameter TIMEOUT, default 255: cycles a selected slave may stall before an error response (1..65535).
REQ-004 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-005 wb_rst_n_i  in  1  reset, asynchronous assert, active-low, synchronous deassert external.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe, write enable.
REQ-007 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32  master byte selects, address, write data.
REQ-008 wbs_ack_o  out  1; wbs_dat_o  out  32  registered acknowledge and read data to master.
REQ-009 s_cyc_o, s_stb_o  out  NS each  one-hot per-slave cycle/strobe.
REQ-010 s_we_o 1, s_sel_o 4, s_adr_o 32, s_dat_o 32  out  latched request shared by all slaves.
REQ-011 s_dat_i  in  NS*32  slave read data, slave k at bits [32k+31:32k]; s_ack_i  in  NS  slave acks.
REQ-012 bus_err_o  out  1  one-cycle pulse per error response; err_adr_o  out  32  address of last error.

Function
REQ-013 FSM states IDLE, BUSY, DONE; exactly one outstanding transaction.
REQ-014 IDLE: wbs_cyc_i&wbs_stb_i latches we/sel/adr/dat into s_* registers and decodes index = wbs_adr_i[18:16].
REQ-015 Decode valid when adr[31:24]==BASE and index<NS; valid -> BUSY, invalid -> DONE with error response.
REQ-016 s_cyc_o/s_stb_o SHALL be combinational: bit[index] high only while state==BUSY, all others 0.
REQ-017 BUSY with s_ack_i[index]=1 -> DONE; wbs_dat_o<=s_dat_i slice (reads) or 0 (writes); acks from unselected slaves ignored.
REQ-018 DONE lasts exactly one cycle with wbs_ack_o=1, then IDLE; request latency = slave ack latency + 1 cycle; no new request accepted in DONE.
REQ-019 Error response: wbs_ack_o=1 in DONE, wbs_dat_o=32'hDEADBEEF, bus_err_o=1 same cycle, err_adr_o<=latched address; writes discarded.
REQ-020 wbs_cyc_i low in BUSY (master abort): -> IDLE next cycle, no wbs_ack_o, no bus_err_o.
REQ-021 Timeout counter (16 bit) clears on IDLE->BUSY, increments each BUSY cycle; reaching TIMEOUT -> DONE with error response.
REQ-022 Slave ack and timeout in same cycle: ack wins, normal response, no error.
REQ-023 Abort and slave ack in same cycle: abort wins, no wbs_ack_o.
REQ-024 wbs_ack_o and bus_err_o low outside DONE; wbs_dat_o holds last value until next DONE.

Reset
REQ-025 wb_rst_n_i low immediately forces state IDLE, counter 0, wbs_ack_o 0, wbs_dat_o 0, bus_err_o 0, err_adr_o 0, s_we_o/s_sel_o/s_adr_o/s_dat_o 0, s_cyc_o/s_stb_o 0.
REQ-026 Reset asserted mid-transaction drops transaction silently; no ack after release until a new request.

Configuration
REQ-027 Macro WB_SLAVE_MUX_TIMEOUT_EN defined: REQ-021/022 timeout logic present.
REQ-028 Macro undefined: no counter, BUSY waits indefinitely for ack or abort; bus_err_o asserts only for decode errors.

Verification
REQ-029 Read adr 32'h3001_0004, slave1 acks 2 cycles after strobe with 32'h1234_5678 -> wbs_ack_o 3 cycles after entering BUSY, wbs_dat_o=32'h1234_5678, only s_stb_o[1] ever high.
REQ-030 Write adr 32'h3005_0000 (NS=4) -> no s_stb_o, ack 1 cycle later, wbs_dat_o=32'hDEADBEEF, bus_err_o pulse, err_adr_o=32'h3005_0000; same for 32'h2000_0000.
REQ-031 With macro, TIMEOUT=8, slave2 never acks -> ack+bus_err_o at BUSY cycle 8 with 32'hDEADBEEF; without macro -> no ack after 1000 cycles.
REQ-032 Slave0 acks exactly on counter==TIMEOUT -> normal data, bus_err_o stays 0.
REQ-033 wbs_cyc_i dropped 2 cycles into BUSY -> s_stb_o all 0 next cycle, no wbs_ack_o; next request served normally.
REQ-034 wb_rst_n_i pulsed low in BUSY -> all outputs 0 immediately, state IDLE, late slave ack after release ignored.
